// File: rtl/cmd_sched.sv
// Command scheduler: prioritised multi-source command intake, gravity DOWN generation,
// session timer FSM and a first-word fall-through command FIFO. Define CMD_DEDUP_EN to
// drop repeated DOWN/LEFT/RIGHT commands that match the FIFO tail.
module cmd_sched #(
   parameter int unsigned NSRC      = 3,
   parameter int unsigned DEPTH     = 16,
   parameter int unsigned SEC_TICK  = 50_000_000,
   parameter int unsigned COUNT_SEC = 60,
   parameter int unsigned DOWN_TICK = 50_000_000,
   parameter int unsigned OVER_TICK = 50_000_000
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [NSRC-1:0]   src_valid_i,
   input  logic [4*NSRC-1:0] src_cmd_i,
   input  logic [2:0]        level_i,
   input  logic              game_end_i,
   output logic [3:0]        cmd_o,
   output logic              cmd_valid_o,
   input  logic              cmd_ready_i,
   output logic              start_o,
   output logic              over_o,
   output logic [6:0]        count_down_o,
   output logic              overflow_o
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned SW = (SEC_TICK > 1) ? $clog2(SEC_TICK) : 1;
   localparam int unsigned GW = $clog2(DOWN_TICK + 1) + 1;
   localparam int unsigned LW = (OVER_TICK > 1) ? $clog2(OVER_TICK) : 1;

   localparam logic [3:0] CmdNone  = 4'd0;
   localparam logic [3:0] CmdInit  = 4'd1;
   localparam logic [3:0] CmdDown  = 4'd2;
   localparam logic [3:0] CmdLeft  = 4'd3;
   localparam logic [3:0] CmdRight = 4'd4;
   localparam logic [3:0] CmdBar   = 4'd9;

   typedef enum logic [1:0] {StIdle, StPlay, StLock, StOver} state_e;

   state_e          state_q, state_d;
   logic [SW-1:0]   sec_cnt_q, sec_cnt_d;
   logic [GW-1:0]   grav_cnt_q, grav_cnt_d;
   logic [LW-1:0]   lock_cnt_q, lock_cnt_d;
   logic [6:0]      count_down_q, count_down_d;
   logic            start_q, start_d;
   logic            over_q, over_d;
   logic            overflow_q;
   logic [3:0]      mem_q [DEPTH];
   logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
   logic [AW:0]     occ_q;

   logic            any_valid, src_hit, grav_pend, push_req, push_eff, flush;
   logic            full, pop, do_push, dup;
   logic [3:0]      src_sel, code, push_cmd;
   logic [GW-1:0]   period, grav_inc;

   assign any_valid = |src_valid_i;
   assign period    = GW'(DOWN_TICK >> level_i);
   assign grav_pend = grav_cnt_q >= period;
   assign grav_inc  = (grav_cnt_q == '1) ? grav_cnt_q : grav_cnt_q + 1'b1;

   // Descending scan so the lowest-index qualifying channel wins.
   always_comb begin
      src_hit = 1'b0;
      src_sel = CmdNone;
      code    = CmdNone;
      for (int i = NSRC - 1; i >= 0; i--) begin
         code = src_cmd_i[4*i +: 4];
         if (src_valid_i[i] && code != CmdNone && code <= CmdBar) begin
            src_hit = 1'b1;
            src_sel = code;
         end
      end
   end

   always_comb begin
      state_d      = state_q;
      sec_cnt_d    = sec_cnt_q;
      grav_cnt_d   = grav_cnt_q;
      lock_cnt_d   = lock_cnt_q;
      count_down_d = count_down_q;
      start_d      = start_q;
      over_d       = over_q;
      push_req     = 1'b0;
      push_cmd     = CmdNone;
      flush        = 1'b0;
      unique case (state_q)
         StIdle, StOver: begin
            if (any_valid) begin
               state_d      = StPlay;
               start_d      = 1'b1;
               over_d       = 1'b0;
               push_req     = 1'b1;
               push_cmd     = CmdInit;
               sec_cnt_d    = '0;
               grav_cnt_d   = '0;
               count_down_d = 7'(COUNT_SEC);
            end
         end
         StPlay: begin
            if (sec_cnt_q == SW'(SEC_TICK - 1)) begin
               sec_cnt_d = '0;
               if (count_down_q != 7'd0) count_down_d = count_down_q - 7'd1;
            end else begin
               sec_cnt_d = sec_cnt_q + 1'b1;
            end
            grav_cnt_d = grav_inc;
            if (src_hit) begin
               push_req = 1'b1;
               push_cmd = src_sel;
            end else if (grav_pend) begin
               push_req   = 1'b1;
               push_cmd   = CmdDown;
               grav_cnt_d = (grav_inc >= period) ? grav_inc - period : '0;
            end
            // Session end wins over any push; the FIFO is flushed on the same edge.
            if (game_end_i || count_down_d == 7'd0) begin
               state_d    = StLock;
               over_d     = 1'b1;
               flush      = 1'b1;
               push_req   = 1'b0;
               lock_cnt_d = '0;
            end
         end
         StLock: begin
            if (lock_cnt_q == LW'(OVER_TICK - 1)) state_d = StOver;
            else lock_cnt_d = lock_cnt_q + 1'b1;
         end
         default: state_d = StIdle;
      endcase
   end

`ifdef CMD_DEDUP_EN
   logic [AW-1:0] tail_ptr;
   assign tail_ptr = wr_ptr_q - 1'b1;
   assign dup = (occ_q >= (AW+1)'(2)) && (push_cmd == mem_q[tail_ptr]) &&
                (push_cmd == CmdDown || push_cmd == CmdLeft || push_cmd == CmdRight);
`else
   assign dup = 1'b0;
`endif

   assign push_eff    = push_req && !dup;
   assign cmd_valid_o = occ_q != '0;
   assign full        = occ_q == (AW+1)'(DEPTH);
   assign pop         = cmd_valid_o && cmd_ready_i;
   assign do_push     = push_eff && (!full || pop);

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q      <= StIdle;
         sec_cnt_q    <= '0;
         grav_cnt_q   <= '0;
         lock_cnt_q   <= '0;
         count_down_q <= 7'(COUNT_SEC);
         start_q      <= 1'b0;
         over_q       <= 1'b0;
         overflow_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         sec_cnt_q    <= sec_cnt_d;
         grav_cnt_q   <= grav_cnt_d;
         lock_cnt_q   <= lock_cnt_d;
         count_down_q <= count_down_d;
         start_q      <= start_d;
         over_q       <= over_d;
         if (push_eff && full && !pop) overflow_q <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n || flush) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         occ_q    <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
         if (do_push && !pop) occ_q <= occ_q + 1'b1;
         else if (!do_push && pop) occ_q <= occ_q - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset_n && do_push) mem_q[wr_ptr_q] <= push_cmd;
   end

   assign cmd_o        = cmd_valid_o ? mem_q[rd_ptr_q] : CmdNone;
   assign start_o      = start_q;
   assign over_o       = over_q;
   assign count_down_o = count_down_q;
   assign overflow_o   = overflow_q;

endmodule

// File: doc/cmd_sched.md
CMD_SCHED -- requirements
Module: cmd_sched

Interface
REQ-001 Parameter NSRC, default 3: number of command source channels; channel 0 has highest priority.
REQ-002 Parameter DEPTH, default 16: command FIFO depth, power of two, at least 2.
REQ-003 Parameter SEC_TICK, default 50_000_000: clk cycles per second.
REQ-004 Parameter COUNT_SEC, default 60: session length in seconds.
REQ-005 Parameter DOWN_TICK, default 50_000_000: base gravity period in cycles at level 0.
REQ-006 Parameter OVER_TICK, default 50_000_000: post-game lockout in cycles.
REQ-007 Port clk, input, 1: clock; all logic is rising-edge.
REQ-008 Port reset_n, input, 1: reset, synchronous, active-low.
REQ-009 Port src_valid, input, NSRC: per-channel one-cycle command strobe.
REQ-010 Port src_cmd, input, 4*NSRC: per-channel command code; channel i is at bits [4i+3:4i].
REQ-011 Port level, input, 3: gravity speed level, 0..7.
REQ-012 Port game_end, input, 1: game engine reports top-out.
REQ-013 Port cmd, output, 4: command at the FIFO head.
REQ-014 Port cmd_valid, output, 1: FIFO is non-empty.
REQ-015 Port cmd_ready, input, 1: consumer pops the head this cycle when cmd_valid is 1.
REQ-016 Port start, output, 1: session is active or over.
REQ-017 Port over, output, 1: session has ended.
REQ-018 Port count_down, output, 7: seconds remaining.
REQ-019 Port overflow, output, 1: sticky flag set when a command was lost.

Function
REQ-020 Command codes: NONE=0, INIT=1, DOWN=2, LEFT=3, RIGHT=4, ROTATE=5, ROTATE_REV=6, DROP=7, HOLD=8, BAR=9. Codes 10..15 are treated as NONE.
REQ-021 Session FSM states: IDLE, PLAY, LOCK, OVER.
- IDLE to PLAY when any src_valid is 1: enqueue INIT, set start=1.
- PLAY to LOCK when count_down==0 or game_end=1: set over=1.
- LOCK to OVER after OVER_TICK cycles.
- OVER to PLAY on any src_valid: clear over, reload count_down to COUNT_SEC, enqueue INIT.
REQ-022 In IDLE, LOCK and OVER, source commands other than the restart trigger in REQ-021 are discarded. In LOCK, all commands are discarded.
REQ-023 In PLAY:
- Select the lowest-index channel with src_valid=1 and a non-NONE code.
- If no channel qualifies, a pending gravity DOWN is the candidate.
- At most one push per cycle.
REQ-024 Gravity counter increments every PLAY cycle. When it reaches or exceeds DOWN_TICK>>level, a gravity DOWN becomes pending.
- On gravity push: subtract the period, saturating at 0.
- If a source command wins instead, the gravity DOWN stays pending.
REQ-025 Second counter wraps at SEC_TICK-1 and decrements count_down during PLAY. count_down saturates at 0.
REQ-026 FIFO is first-word fall-through.
- cmd equals the head entry when cmd_valid=1, else NONE.
- A pop takes effect at the clock edge where cmd_valid and cmd_ready are both 1.
REQ-027 Push while full and no pop in the same cycle: incoming command is dropped, overflow set to 1. overflow clears only on reset.
REQ-028 Simultaneous push and pop while full: both succeed, occupancy unchanged.
REQ-029 Simultaneous push and pop while empty: pushed entry appears at the head on the next cycle.
REQ-030 Read and write pointers are log2(DEPTH) bits and wrap modulo DEPTH. Occupancy is log2(DEPTH)+1 bits.
REQ-031 Entering LOCK flushes the FIFO: empty on the following cycle.

Reset
REQ-032 While reset_n=0 at a clock edge, the block enters IDLE and clears FIFO, counters, start, over and overflow, with cmd_valid=0 and cmd=NONE. count_down is set to COUNT_SEC.
REQ-033 Reset asserted mid-session or mid-pop discards all state; no pop is honoured in that cycle.

Configuration
REQ-034 Macro CMD_DEDUP_EN.
- When defined: a DOWN, LEFT or RIGHT command equal to the current tail entry while FIFO occupancy is 2 or more is discarded silently, with no overflow.
- When undefined: every qualifying command is pushed.

Verification
REQ-035 Reset, then src_valid[1]=1 with LEFT -> cmd=INIT and cmd_valid=1 next cycle, start=1. LEFT is not queued.
REQ-036 PLAY, channels 0 and 2 strobe RIGHT and DROP in the same cycle -> only RIGHT is queued, with no pop.
REQ-037 PLAY with DOWN_TICK=8, level=1, cmd_ready=1, no sources -> DOWN pushed every 4 cycles.
REQ-038 DEPTH=4, cmd_ready=0, 5 distinct pushes -> occupancy 4, overflow=1, head is the first command.
REQ-039 COUNT_SEC=2, SEC_TICK=10 -> over=1 at cycle 20 of PLAY, FIFO empty next cycle, restart ignored until OVER_TICK elapses.
REQ-040 CMD_DEDUP_EN defined, two LEFT strobes with occupancy 2 -> occupancy 3. Undefined -> occupancy 4.
